branch_target_buffer: RTL and testbench
=======================================

// Module: branch_target_buffer
// PURPOSE
//   Direct-mapped Branch Target Buffer (BTB) for the fetch stage of the RISC-V pipeline.
//   Combinationally looks up the fetch PC and returns a predicted target on a hit.
//   Execute-stage branch resolution writes entries: PC_Ex is the branch address,
//   PC_ALU is the computed target. Hit/Target_Add drive the fetch-stage next-PC mux.
// PARAMETERS
//   WIDTH_DATA_LENGTH   32  address/data width
//   WIDTH_TAG_LENGTH    27  tag width = WIDTH_DATA_LENGTH-2-WIDTH_ENTRY_LENTH
//   WIDTH_ENTRY_LENTH   3   index width
//   ENTRY_DEPTH_LENGTH  8   number of entries = 1<<WIDTH_ENTRY_LENTH
// PORTS
//   clk          in   1   clock, rising-edge active
//   rst_n        in   1   asynchronous reset, active-low
//   PC           in   32  fetch-stage PC (lookup address)
//   PC_Ex        in   32  PC of the branch resolved in execute (write address)
//   PC_ALU       in   32  resolved branch target (write data)
//   Br_Detected  in   1   write enable: taken branch resolved this cycle
//   Hit          out  1   lookup hit for PC
//   Target_Add   out  32  predicted next fetch address
// BEHAVIOUR
//   - Address split: byte offset [1:0] ignored; index = A[4:2]; tag = A[31:5].
//   - Per entry: valid (1b), tag (27b), target (32b).
//   - Lookup (combinational, 0-cycle latency):
//     Hit = valid[PC idx] && (tag[PC idx] == PC tag).
//     Target_Add = Hit ? target[PC idx] : PC + 4 (32-bit, wraps modulo 2^32).
//   - Update (rising clk, when Br_Detected=1): entry[PC_Ex idx] <=
//     {valid=1, tag=PC_Ex tag, target=PC_ALU}. Any existing entry at that index is
//     overwritten unconditionally (aliasing replacement, no LRU).
//   - Br_Detected=0: no state change.
//   - Same-cycle read/write of the same index: lookup returns pre-edge contents.
//     New contents are visible combinationally immediately after the edge.
//   - Reset (rst_n=0, asynchronous, any time incl. mid-operation):
//     all valid<=0, tags<=0, targets<=0.
//     Outputs follow combinationally: Hit=0, Target_Add=PC+4.
//     Writes are blocked while rst_n=0.
//   - Re-writing an entry with an identical tag updates only its target.
//   - Outputs are X-free whenever PC is known, since all state is reset.
// TESTING
//   1. Reset, PC=0x1234_0000 -> Hit=0, Target_Add=0x1234_0004.
//   2. Br_Detected=1, PC_Ex=0x1234_0000, PC_ALU=0xFFFF_AAAA, one clk edge; PC=0x1234_0000
//      -> Hit=1, Target_Add=0xFFFF_AAAA.
//   3. Write PC_Ex=0x1234_0004, PC_ALU=0x1414_1414 (index 1).
//      PC=0x1234_0004 -> Hit=1, Target_Add=0x1414_1414.
//      PC=0x1234_0000 still returns 0xFFFF_AAAA.
//   4. Overwrite PC_Ex=0x1234_0000 with PC_ALU=0xAAAA_AAAA -> Target_Add=0xAAAA_AAAA.
//      Then Br_Detected=0 with PC_ALU changing -> entries unchanged.
//   5. Aliasing: PC=0x1234_0020 (index 0, different tag) -> Hit=0, Target_Add=0x1234_0024.
//      Write it; PC=0x1234_0000 -> miss.
//   6. Assert rst_n=0 between clock edges after step 3 -> Hit=0 immediately.
//      PC=0xFFFF_FFFC -> Target_Add=0x0000_0000.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the fetch stage: zero-latency lookup of the
// fetch PC, written from execute-stage branch resolution with aliasing replacement.
module branch_target_buffer #(
    parameter int WIDTH_DATA_LENGTH  = 32,
    parameter int WIDTH_ENTRY_LENTH  = 3,
    parameter int WIDTH_TAG_LENGTH   = WIDTH_DATA_LENGTH - 2 - WIDTH_ENTRY_LENTH,
    parameter int ENTRY_DEPTH_LENGTH = 1 << WIDTH_ENTRY_LENTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_Ex,
    input  logic [WIDTH_DATA_LENGTH-1:0] PC_ALU,
    input  logic                         Br_Detected,
    output logic                         Hit,
    output logic [WIDTH_DATA_LENGTH-1:0] Target_Add
);

    localparam int IDX_LO = 2;
    localparam int IDX_HI = WIDTH_ENTRY_LENTH + 1;
    localparam int TAG_LO = WIDTH_ENTRY_LENTH + 2;

    logic                         valid_r  [ENTRY_DEPTH_LENGTH];
    logic [WIDTH_TAG_LENGTH-1:0]  tag_r    [ENTRY_DEPTH_LENGTH];
    logic [WIDTH_DATA_LENGTH-1:0] target_r [ENTRY_DEPTH_LENGTH];

    logic [WIDTH_ENTRY_LENTH-1:0] rd_idx_s;
    logic [WIDTH_TAG_LENGTH-1:0]  rd_tag_s;
    logic [WIDTH_ENTRY_LENTH-1:0] wr_idx_s;
    logic [WIDTH_TAG_LENGTH-1:0]  wr_tag_s;
    logic                         hit_s;
    logic [WIDTH_DATA_LENGTH-1:0] target_s;
    logic                         unused_offset_s;

    // Byte-offset bits never take part in indexing or tag matching.
    assign unused_offset_s = ^{PC[1:0], PC_Ex[1:0]};

    // Split lookup and write addresses into index and tag fields.
    always_comb begin
        rd_idx_s = PC[IDX_HI:IDX_LO];
        rd_tag_s = PC[WIDTH_DATA_LENGTH-1:TAG_LO];
        wr_idx_s = PC_Ex[IDX_HI:IDX_LO];
        wr_tag_s = PC_Ex[WIDTH_DATA_LENGTH-1:TAG_LO];
    end

    // Entry storage: cleared on reset, overwritten at the resolved branch's index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_DEPTH_LENGTH; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {WIDTH_TAG_LENGTH{1'b0}};
                target_r[i] <= {WIDTH_DATA_LENGTH{1'b0}};
            end
        end else if (Br_Detected) begin
            valid_r[wr_idx_s]  <= 1'b1;
            tag_r[wr_idx_s]    <= wr_tag_s;
            target_r[wr_idx_s] <= PC_ALU;
        end
    end

    // Lookup is combinational so fetch can redirect in the same cycle; a miss
    // falls through to the sequential PC.
    always_comb begin
        hit_s    = 1'b0;
        target_s = PC + WIDTH_DATA_LENGTH'(4);
        if (valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s)) begin
            hit_s    = 1'b1;
            target_s = target_r[rd_idx_s];
        end else begin
            hit_s    = 1'b0;
            target_s = PC + WIDTH_DATA_LENGTH'(4);
        end
    end

    assign Hit        = hit_s;
    assign Target_Add = target_s;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: a per-cycle compare against an
// index/tag model plus directed literal checks of the key scenarios.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PC;
    logic [31:0] PC_Ex;
    logic [31:0] PC_ALU;
    logic        Br_Detected;
    logic        Hit;
    logic [31:0] Target_Add;

    int tests  = 0;
    int fails  = 0;
    bit check_en = 1'b0;

    // Model: one slot per index; bit i of m_live says slot i holds a branch.
    logic [7:0]  m_live = 8'h00;
    logic [31:0] m_tag [8];
    logic [31:0] m_tgt [8];

    branch_target_buffer dut (
        .clk(clk), .rst_n(rst_n), .PC(PC), .PC_Ex(PC_Ex), .PC_ALU(PC_ALU),
        .Br_Detected(Br_Detected), .Hit(Hit), .Target_Add(Target_Add)
    );

    always #5 clk = ~clk;

    // Model update: remember the last branch seen at each index.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_live <= 8'h00;
        end else if (Br_Detected) begin
            m_live[(PC_Ex >> 2) % 8] <= 1'b1;
            m_tag[(PC_Ex >> 2) % 8]  <= PC_Ex >> 5;
            m_tgt[(PC_Ex >> 2) % 8]  <= PC_ALU;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin : cmp
        int unsigned slot;
        logic        e_hit;
        logic [31:0] e_tgt;
        if (check_en) begin
            slot  = (PC >> 2) % 8;
            e_hit = rst_n && m_live[slot] && (m_tag[slot] == (PC >> 5));
            e_tgt = e_hit ? m_tgt[slot] : PC + 32'd4;
            tests++;
            if (Hit !== e_hit || Target_Add !== e_tgt) begin
                fails++;
                $display("FAIL model_cmp t=%0t PC=%h got Hit=%b Target=%h want Hit=%b Target=%h",
                         $time, PC, Hit, Target_Add, e_hit, e_tgt);
            end
        end
    end

    task automatic chk(input string name, input logic e_hit, input logic [31:0] e_tgt);
        tests++;
        if (Hit !== e_hit || Target_Add !== e_tgt) begin
            fails++;
            $display("FAIL %s got Hit=%b Target=%h want Hit=%b Target=%h",
                     name, Hit, Target_Add, e_hit, e_tgt);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ex,
                         input logic [31:0] alu, input logic br);
        @(posedge clk);
        #1;
        PC = pc; PC_Ex = ex; PC_ALU = alu; Br_Detected = br;
        #1;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        PC = pc;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; PC = 32'h1234_0000; PC_Ex = 32'h0; PC_ALU = 32'h0; Br_Detected = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_miss", 1'b0, 32'h1234_0004);
        rst_n = 1'b1;
        check_en = 1'b1;

        // First write: invisible until the edge, visible right after.
        drive(32'h1234_0000, 32'h1234_0000, 32'hFFFF_AAAA, 1'b1);
        chk("pre_write_miss", 1'b0, 32'h1234_0004);
        drive(32'h1234_0000, 32'h1234_0000, 32'hFFFF_AAAA, 1'b0);
        chk("write_idx0_hit", 1'b1, 32'hFFFF_AAAA);

        drive(32'h1234_0004, 32'h1234_0004, 32'h1414_1414, 1'b1);
        chk("idx1_pre_edge", 1'b0, 32'h1234_0008);
        drive(32'h1234_0004, 32'h1234_0004, 32'h1414_1414, 1'b0);
        chk("idx1_hit", 1'b1, 32'h1414_1414);
        set_pc(32'h1234_0000);
        chk("idx0_kept", 1'b1, 32'hFFFF_AAAA);

        // Overwrite same tag: same-cycle lookup still sees old target.
        drive(32'h1234_0000, 32'h1234_0000, 32'hAAAA_AAAA, 1'b1);
        chk("same_cycle_old", 1'b1, 32'hFFFF_AAAA);
        drive(32'h1234_0000, 32'h1234_0000, 32'h5555_5555, 1'b0);
        chk("overwrite_new", 1'b1, 32'hAAAA_AAAA);
        drive(32'h1234_0000, 32'h1234_0000, 32'h1212_1212, 1'b0);
        chk("no_write_hold", 1'b1, 32'hAAAA_AAAA);

        // Aliasing on index 0 with a different tag.
        set_pc(32'h1234_0020);
        chk("alias_miss", 1'b0, 32'h1234_0024);
        drive(32'h1234_0020, 32'h1234_0020, 32'hDEAD_BEEF, 1'b1);
        drive(32'h1234_0020, 32'h1234_0000, 32'h0, 1'b0);
        chk("alias_hit", 1'b1, 32'hDEAD_BEEF);
        set_pc(32'h1234_0000);
        chk("alias_evicted", 1'b0, 32'h1234_0004);
        set_pc(32'h1234_0004);
        chk("idx1_survives", 1'b1, 32'h1414_1414);

        // Asynchronous reset between edges, with a write pending.
        PC_Ex = 32'h1234_0008; PC_ALU = 32'h7777_7777; Br_Detected = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_miss", 1'b0, 32'h1234_0008);
        set_pc(32'hFFFF_FFFC);
        chk("rst_wrap", 1'b0, 32'h0000_0000);
        drive(32'h1234_0008, 32'h1234_0008, 32'h7777_7777, 1'b1);
        chk("write_blocked", 1'b0, 32'h1234_000C);
        Br_Detected = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_miss", 1'b0, 32'h1234_000C);

        // Top index, top tag; byte offset ignored on lookup.
        drive(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0100, 1'b1);
        drive(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0100, 1'b0);
        chk("idx7_hit", 1'b1, 32'h0000_0100);
        set_pc(32'hFFFF_FFFF);
        chk("offset_ignored", 1'b1, 32'h0000_0100);
        set_pc(32'h7FFF_FFFC);
        chk("idx7_tag_diff", 1'b0, 32'h8000_0000);

        @(posedge clk);
        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
